// File: rtl/sparse_mac_reader.sv
// Sparse dot-product reader: takes matched (a_idx, b_idx) pairs, fetches both
// operands from external value memories, and accumulates one result per row.
module sparse_mac_reader #(
    parameter int DW = 8,
    parameter int AW = 19
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pair_valid,
    input  logic [5:0]    pair_data,
    input  logic          pair_last,
    output logic          pair_ready,
    output logic [2:0]    a_raddr,
    output logic [2:0]    b_raddr,
    input  logic [DW-1:0] a_rdata,
    input  logic [DW-1:0] b_rdata,
    output logic          res_valid,
    output logic [AW-1:0] res_data,
    output logic [3:0]    res_count,
    input  logic          res_ready,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ACC   = 2'd2,
        EMIT  = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] acc_q, acc_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          last_q, last_d;
    logic [2:0]    a_raddr_q, a_raddr_d;
    logic [2:0]    b_raddr_q, b_raddr_d;
    logic [2*DW-1:0] product;

    assign product = {{DW{1'b0}}, a_rdata} * {{DW{1'b0}}, b_rdata};

    always_comb begin
        // NOTE: every _d gets its hold value first so no path leaves it unassigned (no latches).
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        a_raddr_d = a_raddr_q;
        b_raddr_d = b_raddr_q;
        case (state_q)
            IDLE: begin
                if (pair_valid) begin
                    a_raddr_d = pair_data[5:3];
                    b_raddr_d = pair_data[2:0];
                    last_d    = pair_last;
                    state_d   = FETCH;
                end
            end
            FETCH: state_d = ACC;
            ACC: begin
                acc_d   = acc_q + AW'(product);
                cnt_d   = (cnt_q == 4'd15) ? cnt_q : cnt_q + 4'd1;
                state_d = last_q ? EMIT : IDLE;
            end
            EMIT: begin
                if (res_ready) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: reset is synchronous, so rst_n is only looked at on the clock edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            cnt_q     <= '0;
            last_q    <= 1'b0;
            a_raddr_q <= '0;
            b_raddr_q <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            a_raddr_q <= a_raddr_d;
            b_raddr_q <= b_raddr_d;
        end
    end

    // Handshake depends on state only, never on pair_valid.
    assign pair_ready = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign a_raddr    = a_raddr_q;
    assign b_raddr    = b_raddr_q;
    assign res_valid  = (state_q == EMIT);
    assign res_data   = (state_q == EMIT) ? acc_q : '0;
    assign res_count  = (state_q == EMIT) ? cnt_q : '0;

endmodule

// File: tb/tb_sparse_mac_reader.sv
// Bench for sparse_mac_reader: directed rows plus random rows, all checked
// against a plain-arithmetic dot-product model of each row.
module tb_sparse_mac_reader;

    localparam int DW = 8;
    localparam int AW = 19;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          pair_valid = 1'b0;
    logic [5:0]    pair_data = '0;
    logic          pair_last = 1'b0;
    logic          res_ready = 1'b0;
    logic          pair_ready, res_valid, busy;
    logic [2:0]    a_raddr, b_raddr;
    logic [DW-1:0] a_rdata, b_rdata;
    logic [AW-1:0] res_data;
    logic [3:0]    res_count;

    logic [DW-1:0] a_mem [0:7];
    logic [DW-1:0] b_mem [0:7];

    int vectors = 0;
    int miscompares = 0;

    int row_a [0:31];
    int row_b [0:31];

    // Observations of the most recent row.
    int            cyc;
    logic [AW-1:0] o_data;
    logic [3:0]    o_count;
    int            o_latency;
    bit            o_timeout;
    int            o_ready_viol;
    int            o_addr_err;
    int            o_stable_err;
    logic          o_post_valid;
    logic          o_post_ready;

    sparse_mac_reader #(.DW(DW), .AW(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pair_valid (pair_valid),
        .pair_data  (pair_data),
        .pair_last  (pair_last),
        .pair_ready (pair_ready),
        .a_raddr    (a_raddr),
        .b_raddr    (b_raddr),
        .a_rdata    (a_rdata),
        .b_rdata    (b_rdata),
        .res_valid  (res_valid),
        .res_data   (res_data),
        .res_count  (res_count),
        .res_ready  (res_ready),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Value memories with one cycle of read latency.
    always @(posedge clk) begin
        a_rdata <= a_mem[a_raddr];
        b_rdata <= b_mem[b_raddr];
    end

    // Reference: dot product of the row, wrapped to AW bits.
    function automatic logic [AW-1:0] ref_sum(input int n);
        longint s = 0;
        for (int i = 0; i < n; i++)
            s += longint'(a_mem[row_a[i]]) * longint'(b_mem[row_b[i]]);
        return AW'(s % (longint'(1) << AW));
    endfunction

    function automatic logic [3:0] ref_count(input int n);
        return (n > 15) ? 4'd15 : 4'(n);
    endfunction

    task automatic clear_obs();
        cyc = 0; o_timeout = 0; o_ready_viol = 0; o_addr_err = 0; o_stable_err = 0;
        o_data = '0; o_count = '0; o_latency = 0; o_post_valid = 1'bx; o_post_ready = 1'bx;
    endtask

    // Offer one pair, wait for acceptance, return at the negedge of the FETCH cycle.
    task automatic accept_pair(input int a, input int b, input bit last, input bit first);
        int k = 0;
        pair_valid = 1'b1;
        pair_data  = {3'(a), 3'(b)};
        pair_last  = last;
        while (pair_ready !== 1'b1) begin
            if (busy !== 1'b1) o_ready_viol++;
            @(negedge clk); cyc++; k++;
            if (k > 60) begin o_timeout = 1; return; end
        end
        if (busy !== 1'b0) o_ready_viol++;
        if (first) cyc = 0;
        @(negedge clk); cyc++;
        if (pair_ready !== 1'b0 || busy !== 1'b1) o_ready_viol++;
        if (a_raddr !== 3'(a) || b_raddr !== 3'(b)) o_addr_err++;
    endtask

    // Push a row of n pairs, hold off res_ready for 'stall' EMIT cycles, then accept.
    task automatic run_row(input int n, input int stall, input bit offer_during_stall);
        int k = 0;
        clear_obs();
        for (int i = 0; i < n; i++) begin
            accept_pair(row_a[i], row_b[i], i == n - 1, i == 0);
            if (o_timeout) begin pair_valid = 1'b0; return; end
        end
        pair_valid = 1'b0;
        pair_last  = 1'b0;
        while (res_valid !== 1'b1) begin
            if (pair_ready !== 1'b0 || busy !== 1'b1) o_ready_viol++;
            @(negedge clk); cyc++; k++;
            if (k > 20) begin o_timeout = 1; return; end
        end
        o_latency = cyc;
        o_data    = res_data;
        o_count   = res_count;
        if (offer_during_stall) begin
            pair_valid = 1'b1;
            pair_data  = 6'h3f;
            pair_last  = 1'b1;
        end
        for (int j = 0; j < stall; j++) begin
            @(negedge clk);
            if (res_valid !== 1'b1 || res_data !== o_data || res_count !== o_count) o_stable_err++;
            if (pair_ready !== 1'b0 || busy !== 1'b1) o_ready_viol++;
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready    = 1'b0;
        o_post_valid = res_valid;
        o_post_ready = pair_ready;
        pair_valid   = 1'b0;
        pair_last    = 1'b0;
    endtask

    // Shared scoring of a finished row against the model.
    task automatic test_row_result(input string name, input int n, input logic [AW-1:0] exp_data);
        vectors++;
        if (o_timeout) begin
            miscompares++;
            $display("FAIL %s_timeout: got timeout expected result within bound", name);
            return;
        end
        vectors++;
        if (o_data !== exp_data) begin
            miscompares++;
            $display("FAIL %s_data: got %0d expected %0d", name, o_data, exp_data);
        end
        vectors++;
        if (o_count !== ref_count(n)) begin
            miscompares++;
            $display("FAIL %s_count: got %0d expected %0d", name, o_count, ref_count(n));
        end
        vectors++;
        if (o_latency !== 3 * n) begin
            miscompares++;
            $display("FAIL %s_latency: got %0d expected %0d", name, o_latency, 3 * n);
        end
        vectors++;
        if (o_addr_err !== 0 || o_ready_viol !== 0 || o_stable_err !== 0) begin
            miscompares++;
            $display("FAIL %s_protocol: got addr_err=%0d ready_viol=%0d stable_err=%0d expected 0/0/0",
                     name, o_addr_err, o_ready_viol, o_stable_err);
        end
        vectors++;
        if (o_post_valid !== 1'b0 || o_post_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL %s_release: got res_valid=%b pair_ready=%b expected 0/1",
                     name, o_post_valid, o_post_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({busy, res_valid, res_data, res_count, a_raddr, b_raddr} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got busy=%b res_valid=%b res_data=%0d res_count=%0d a=%0d b=%0d expected all 0",
                     busy, res_valid, res_data, res_count, a_raddr, b_raddr);
        end
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (pair_ready !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release: got pair_ready=%b busy=%b expected 1/0", pair_ready, busy);
        end
    endtask

    task automatic test_single();
        a_mem[3] = 8'd10;
        b_mem[5] = 8'd20;
        row_a[0] = 3; row_b[0] = 5;
        run_row(1, 0, 0);
        test_row_result("single", 1, 19'd200);
    endtask

    task automatic test_three_pair();
        a_mem[0] = 8'd2; b_mem[0] = 8'd3;
        a_mem[1] = 8'd4; b_mem[1] = 8'd5;
        a_mem[2] = 8'd6; b_mem[2] = 8'd7;
        for (int i = 0; i < 3; i++) begin row_a[i] = i; row_b[i] = i; end
        run_row(3, 0, 0);
        test_row_result("three_pair", 3, 19'd68);
    endtask

    task automatic test_backpressure();
        a_mem[6] = 8'd9; b_mem[2] = 8'd11;
        a_mem[4] = 8'd13; b_mem[7] = 8'd3;
        row_a[0] = 6; row_b[0] = 2;
        row_a[1] = 4; row_b[1] = 7;
        run_row(2, 5, 1);
        test_row_result("backpressure", 2, ref_sum(2));
    endtask

    task automatic test_max_row();
        for (int i = 0; i < 8; i++) begin
            a_mem[i] = 8'd255; b_mem[i] = 8'd255;
            row_a[i] = i; row_b[i] = 7 - i;
        end
        run_row(8, 1, 0);
        test_row_result("max_row", 8, 19'd520200);
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 8; i++) begin a_mem[i] = 8'd255; b_mem[i] = 8'd255; end
        for (int i = 0; i < 17; i++) begin row_a[i] = i % 8; row_b[i] = (i * 3) % 8; end
        run_row(17, 0, 0);
        // 17 * 65025 = 1105425, wrapped to 19 bits.
        test_row_result("saturation", 17, AW'(1105425 % (1 << AW)));
    endtask

    task automatic test_reset_mid_row();
        clear_obs();
        a_mem[0] = 8'd50; b_mem[0] = 8'd60;
        accept_pair(0, 0, 1'b0, 1'b1);
        accept_pair(0, 0, 1'b0, 1'b0);
        pair_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (o_timeout || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL midrow_setup: got timeout=%0d busy=%b expected 0/1", o_timeout, busy);
        end
        rst_n = 1'b0;
        @(negedge clk);
        vectors++;
        if ({busy, res_valid, res_data, res_count, a_raddr, b_raddr} !== '0) begin
            miscompares++;
            $display("FAIL midrow_reset: got busy=%b res_valid=%b res_data=%0d res_count=%0d a=%0d b=%0d expected all 0",
                     busy, res_valid, res_data, res_count, a_raddr, b_raddr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        a_mem[1] = 8'd4; b_mem[1] = 8'd4;
        row_a[0] = 1; row_b[0] = 1;
        run_row(1, 0, 0);
        test_row_result("midrow_next", 1, 19'd16);
    endtask

    task automatic test_duplicates();
        a_mem[5] = 8'd17; b_mem[3] = 8'd23;
        for (int i = 0; i < 3; i++) begin row_a[i] = 5; row_b[i] = 3; end
        run_row(3, 0, 0);
        test_row_result("duplicates", 3, 19'(3 * 17 * 23));
    endtask

    task automatic test_random_rows();
        for (int r = 0; r < 12; r++) begin
            int n;
            int stall;
            n     = $urandom_range(1, 7);
            stall = $urandom_range(0, 3);
            for (int i = 0; i < 8; i++) begin
                a_mem[i] = 8'($urandom);
                b_mem[i] = 8'($urandom);
            end
            for (int i = 0; i < n; i++) begin
                row_a[i] = $urandom_range(0, 7);
                row_b[i] = $urandom_range(0, 7);
            end
            run_row(n, stall, r % 2 == 1);
            test_row_result($sformatf("random%0d", r), n, ref_sum(n));
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin a_mem[i] = '0; b_mem[i] = '0; end
        test_reset();
        test_single();
        test_three_pair();
        test_backpressure();
        test_max_row();
        test_saturation();
        test_reset_mid_row();
        test_duplicates();
        test_random_rows();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
